// File: rtl/k423_id_scoreboard_pkg.sv
// Shared core widths and scoreboard defaults for the k423 decode stage.
// Imported by the scoreboard top and its per-register counter.
package k423_id_scoreboard_pkg;

   localparam int CORE_XLEN     = 32;
   localparam int INST_RSDIDX_W = 5;
   localparam int SB_CNT_W      = 2;
   localparam int SB_REG_NUM    = 32;

endpackage

// File: rtl/k423_sb_cnt.sv
// Per-register pending-write counter: saturating up/down with a synchronous
// clear and a combinational flag for a decrement arriving at zero.
module k423_sb_cnt
   import k423_id_scoreboard_pkg::*;
#(
   parameter int CNT_W = SB_CNT_W
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_inc,
   input  logic i_dec,
   input  logic i_clr,
   output logic o_pend,
   output logic o_full,
   output logic o_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_dec && !i_inc && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_pend = (r_cnt != '0);
   assign o_full = (r_cnt == CNT_MAX);
   // A writeback that meets an empty counter is spurious unless it is being flushed.
   assign o_err  = i_dec & ~i_clr & (r_cnt == '0);

endmodule

// File: rtl/k423_id_scoreboard.sv
// Decode-stage register scoreboard: tracks outstanding writes per register and
// gates the ID->EX valid/ready pair on RAW hazards and saturated destinations.
module k423_id_scoreboard
   import k423_id_scoreboard_pkg::*;
#(
   parameter int REG_NUM = SB_REG_NUM,
   parameter int CNT_W   = SB_CNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     id_vld_i,
   input  logic                     ex_rdy_i,
   input  logic                     rs1_vld_i,
   input  logic                     rs2_vld_i,
   input  logic                     rd_vld_i,
   input  logic [INST_RSDIDX_W-1:0] rs1_idx_i,
   input  logic [INST_RSDIDX_W-1:0] rs2_idx_i,
   input  logic [INST_RSDIDX_W-1:0] rd_idx_i,
   input  logic                     wb_vld_i,
   input  logic [INST_RSDIDX_W-1:0] wb_idx_i,
   input  logic                     flush_i,
   output logic                     id_vld_o,
   output logic                     id_rdy_o,
   output logic                     stall_o,
   output logic                     busy_o,
   output logic                     err_o
);

   // Handshake: an instruction moves ID->EX on a cycle where id_vld_o and
   // ex_rdy_i are both high; id_rdy_o tells fetch the ID slot frees this cycle.

   logic [REG_NUM-1:0] w_pend;
   logic [REG_NUM-1:0] w_full;
   logic [REG_NUM-1:0] w_err;
   logic               w_stall;
   logic               w_fire;
   logic               r_err;

   // x0 is hardwired zero, so it never pends, saturates or errors.
   assign w_pend[0] = 1'b0;
   assign w_full[0] = 1'b0;
   assign w_err[0]  = 1'b0;

   for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
      localparam logic [INST_RSDIDX_W-1:0] IDX = INST_RSDIDX_W'(g);

      k423_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .i_clk   (clk_i),
         .i_rst_n (rst_n_i),
         .i_inc   (w_fire & rd_vld_i & (rd_idx_i == IDX)),
         .i_dec   (wb_vld_i & (wb_idx_i == IDX)),
         .i_clr   (flush_i),
         .o_pend  (w_pend[g]),
         .o_full  (w_full[g]),
         .o_err   (w_err[g])
      );
   end

   // Hazards are judged on registered counts only; a same-cycle writeback
   // releases the stall one cycle later.
   assign w_stall = id_vld_i & ((rs1_vld_i & w_pend[rs1_idx_i]) |
                                (rs2_vld_i & w_pend[rs2_idx_i]) |
                                (rd_vld_i  & w_full[rd_idx_i]));
   assign w_fire  = id_vld_i & ex_rdy_i & ~w_stall;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_err <= 1'b0;
      end else if (|w_err) begin
         r_err <= 1'b1;
      end
   end

   assign stall_o  = w_stall;
   assign id_vld_o = id_vld_i & ~w_stall;
   assign id_rdy_o = ~id_vld_i | (~w_stall & ex_rdy_i);
   assign busy_o   = |w_pend;
   assign err_o    = r_err;

endmodule

// File: tb/tb_k423_id_scoreboard.sv
// Bench for k423_id_scoreboard: directed scenarios plus random traffic,
// checked against a per-register pending-count model.
module tb_k423_id_scoreboard;

   localparam int NREG = 32;
   localparam int MAXC = 3;

   logic       clk = 1'b0;
   logic       rst_n_i;
   logic       id_vld_i, ex_rdy_i, rs1_vld_i, rs2_vld_i, rd_vld_i;
   logic [4:0] rs1_idx_i, rs2_idx_i, rd_idx_i, wb_idx_i;
   logic       wb_vld_i, flush_i;
   logic       id_vld_o, id_rdy_o, stall_o, busy_o, err_o;

   int m_cnt [NREG];
   bit m_err;
   int n_tests = 0;
   int n_fail  = 0;

   k423_id_scoreboard dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n_i),
      .id_vld_i  (id_vld_i),
      .ex_rdy_i  (ex_rdy_i),
      .rs1_vld_i (rs1_vld_i),
      .rs2_vld_i (rs2_vld_i),
      .rd_vld_i  (rd_vld_i),
      .rs1_idx_i (rs1_idx_i),
      .rs2_idx_i (rs2_idx_i),
      .rd_idx_i  (rd_idx_i),
      .wb_vld_i  (wb_vld_i),
      .wb_idx_i  (wb_idx_i),
      .flush_i   (flush_i),
      .id_vld_o  (id_vld_o),
      .id_rdy_o  (id_rdy_o),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_stall();
      bit h1, h2, hd;
      h1 = rs1_vld_i && (rs1_idx_i != 0) && (m_cnt[rs1_idx_i] > 0);
      h2 = rs2_vld_i && (rs2_idx_i != 0) && (m_cnt[rs2_idx_i] > 0);
      hd = rd_vld_i  && (rd_idx_i  != 0) && (m_cnt[rd_idx_i] == MAXC);
      return id_vld_i && (h1 || h2 || hd);
   endfunction

   function automatic bit model_busy();
      for (int r = 1; r < NREG; r++)
         if (m_cnt[r] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input bit v, input bit er, input bit r1v, input int r1,
                        input bit r2v, input int r2, input bit rdv, input int rd,
                        input bit wv, input int wb, input bit fl);
      id_vld_i  = v;    ex_rdy_i  = er;
      rs1_vld_i = r1v;  rs1_idx_i = r1[4:0];
      rs2_vld_i = r2v;  rs2_idx_i = r2[4:0];
      rd_vld_i  = rdv;  rd_idx_i  = rd[4:0];
      wb_vld_i  = wv;   wb_idx_i  = wb[4:0];
      flush_i   = fl;
   endtask

   task automatic idle();
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called at a negedge with inputs applied: checks the combinational outputs,
   // advances the model across one edge, then checks the registered outputs.
   task automatic step(input string tag);
      bit s, fire;
      #1;
      s = model_stall();
      check({tag, "_stall"}, {31'd0, stall_o}, {31'd0, s});
      check({tag, "_id_vld"}, {31'd0, id_vld_o}, {31'd0, id_vld_i & ~s});
      check({tag, "_id_rdy"}, {31'd0, id_rdy_o}, {31'd0, ~id_vld_i | (~s & ex_rdy_i)});
      fire = id_vld_i && ex_rdy_i && !s;
      if (flush_i) begin
         for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      end else begin
         if (wb_vld_i && (wb_idx_i != 0) && (m_cnt[wb_idx_i] == 0)) m_err = 1'b1;
         if (fire && rd_vld_i && (rd_idx_i != 0)) m_cnt[rd_idx_i]++;
         if (wb_vld_i && (wb_idx_i != 0) && (m_cnt[wb_idx_i] > 0)) m_cnt[wb_idx_i]--;
      end
      @(posedge clk);
      #1;
      check({tag, "_busy"}, {31'd0, busy_o}, {31'd0, model_busy()});
      check({tag, "_err"}, {31'd0, err_o}, {31'd0, m_err});
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      idle();
      rst_n_i = 1'b0;
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      #1;
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_err"}, {31'd0, err_o}, 32'd0);
      check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
      check({tag, "_id_rdy"}, {31'd0, id_rdy_o}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
   endtask

   initial begin
      rst_n_i = 1'b0;
      idle();
      @(negedge clk);
      do_reset("rst");

      // Producer x5 then dependent on x5: stall until the cycle after its writeback.
      drive(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step("tp1_issue");
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("tp1_dep0");
      check("tp1_stall_held", {31'd0, stall_o}, 32'd1);
      step("tp1_dep1");
      drive(1, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0); step("tp1_wb");
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      #1 check("tp1_released", {31'd0, stall_o}, 32'd0);
      step("tp1_fire");

      // x0 is never tracked.
      drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step("tp2_rd0");
      drive(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("tp2_rs0");

      // Saturate x7, fourth issue stalls, one writeback releases it.
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0); step("tp3_fill");
      end
      step("tp3_full");
      drive(1, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0); step("tp3_wb");
      drive(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0); step("tp3_refire");
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("tp3_drain");
      end

      // Same-cycle increment and decrement on x3 leave the count unchanged.
      drive(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("tp4_issue");
      drive(1, 1, 0, 0, 0, 0, 1, 3, 1, 3, 0); step("tp4_both");
      drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0); step("tp4_pend");
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0); step("tp4_drain");

      // Flush wins over a same-cycle fire and writeback.
      drive(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0); step("tp5_a");
      step("tp5_b");
      drive(1, 1, 0, 0, 0, 0, 1, 10, 1, 9, 1); step("tp5_flush");
      idle(); step("tp5_after");

      // Spurious writeback sets a sticky error that only reset clears.
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0); step("tp6_wb");
      idle();
      for (int k = 0; k < 3; k++) step("tp6_hold");
      check("tp6_sticky", {31'd0, err_o}, 32'd1);
      do_reset("tp6_rst");
      idle(); step("tp6_clear");

      for (int i = 0; i < 1500; i++) begin
         int w;
         bit wv;
         w  = $urandom_range(1, 7);
         wv = (m_cnt[w] > 0) && ($urandom_range(0, 1) == 1);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7),
               wv, w, $urandom_range(0, 39) == 0);
         step("rnd");
         if (i == 750) do_reset("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
